// File: rtl/sm4_request_arbiter_if.sv
// Requester, encryptor and control signals of sm4_request_arbiter bundled in one place.
// The arbiter connects through the master modport; requesters/encryptor/control use slave.
interface sm4_request_arbiter_if #(
    parameter int num_req_p         = 4,
    parameter int max_outstanding_p = 4
);
    localparam int group_size_p = 128;
    localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);

    logic [num_req_p-1:0]              req_v_i;
    logic [num_req_p-1:0]              req_ready_o;
    logic [num_req_p*group_size_p-1:0] req_content_i;
    logic [num_req_p*group_size_p-1:0] req_key_i;
    logic [num_req_p-1:0]              req_decode_i;
    logic [num_req_p-1:0]              resp_v_o;
    logic [num_req_p-1:0]              resp_yumi_i;
    logic [group_size_p-1:0]           resp_crypt_o;
    logic [group_size_p-1:0]           enc_content_o;
    logic [group_size_p-1:0]           enc_key_o;
    logic                              enc_decode_o;
    logic                              enc_v_o;
    logic                              enc_ready_i;
    logic [group_size_p-1:0]           enc_crypt_i;
    logic                              enc_v_i;
    logic                              enc_yumi_o;
    logic                              enc_invalid_cache_o;
    logic                              flush_i;
    logic                              flush_done_o;
    logic [cnt_width_lp-1:0]           outstanding_o;
    logic                              error_o;

    modport master (
        input  req_v_i, req_content_i, req_key_i, req_decode_i, resp_yumi_i,
        input  enc_ready_i, enc_crypt_i, enc_v_i, flush_i,
        output req_ready_o, resp_v_o, resp_crypt_o,
        output enc_content_o, enc_key_o, enc_decode_o, enc_v_o, enc_yumi_o,
        output enc_invalid_cache_o, flush_done_o, outstanding_o, error_o
    );

    modport slave (
        output req_v_i, req_content_i, req_key_i, req_decode_i, resp_yumi_i,
        output enc_ready_i, enc_crypt_i, enc_v_i, flush_i,
        input  req_ready_o, resp_v_o, resp_crypt_o,
        input  enc_content_o, enc_key_o, enc_decode_o, enc_v_o, enc_yumi_o,
        input  enc_invalid_cache_o, flush_done_o, outstanding_o, error_o
    );
endinterface

// File: rtl/sm4_request_arbiter.sv
// Round-robin share of one in-order SM4 encryptor; zero-latency grant, tag FIFO routes results back.
// Issue stalls on a full tag FIFO or during flush drain; results stall on the head requester's yumi.
module sm4_request_arbiter #(
    parameter int num_req_p         = 4,
    parameter int max_outstanding_p = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    sm4_request_arbiter_if.master bus
);
    localparam int group_size_p = 128;
    localparam int id_width_lp  = $clog2(num_req_p);
    localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);
    localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLUSH} state_e;

    state_e                  r_state, w_state_nxt;
    logic                    r_post_rst;
    logic                    r_error;
    logic [id_width_lp-1:0]  r_rr_ptr;
    logic [id_width_lp-1:0]  r_fifo_mem [max_outstanding_p];
    logic [ptr_width_lp-1:0] r_wr_ptr, r_rd_ptr;
    logic [cnt_width_lp-1:0] r_count;

    logic                    w_out_en, w_in_run, w_flush_pulse;
    logic                    w_fifo_empty, w_fifo_full;
    logic [id_width_lp-1:0]  w_grant, w_rr_nxt, w_head;
    logic [id_width_lp:0]    w_sum;
    logic                    w_can_issue, w_issue, w_resp_hit, w_pop, w_spurious;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    // Outputs are held at zero during reset and for the one cycle that follows it.
    assign w_out_en     = !reset_i && !r_post_rst;
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == cnt_width_lp'(max_outstanding_p));

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= ST_RUN;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (bus.flush_i) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_fifo_empty) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_in_run      = 1'b0;
        w_flush_pulse = 1'b0;
        case (r_state)
            ST_RUN:   w_in_run      = w_out_en;
            ST_FLUSH: w_flush_pulse = w_out_en;
            default:  ;
        endcase
    end

    // First requesting lane at or after r_rr_ptr, wrapping.
    always_comb begin
        w_grant = '0;
        w_sum   = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (id_width_lp + 1)'(k);
            if (w_sum >= (id_width_lp + 1)'(num_req_p))
                w_sum = w_sum - (id_width_lp + 1)'(num_req_p);
            if (bus.req_v_i[w_sum[id_width_lp-1:0]]) w_grant = w_sum[id_width_lp-1:0];
        end
    end

    assign w_rr_nxt    = (w_grant == id_width_lp'(num_req_p - 1)) ? '0 : w_grant + id_width_lp'(1);
    assign w_can_issue = w_in_run && (|bus.req_v_i) && !w_fifo_full;
    assign w_issue     = w_can_issue && bus.enc_ready_i;

    assign bus.enc_v_o       = w_can_issue;
    assign bus.enc_content_o = w_can_issue ? bus.req_content_i[{w_grant, 7'b0} +: group_size_p] : '0;
    assign bus.enc_key_o     = w_can_issue ? bus.req_key_i[{w_grant, 7'b0} +: group_size_p] : '0;
    assign bus.enc_decode_o  = w_can_issue && bus.req_decode_i[w_grant];
    assign bus.req_ready_o   = w_issue ? (num_req_p'(1) << w_grant) : '0;

    // A result with no tag to route it is dropped and flagged.
    assign w_head     = r_fifo_mem[r_rd_ptr];
    assign w_resp_hit = w_out_en && bus.enc_v_i && !w_fifo_empty;
    assign w_spurious = w_out_en && bus.enc_v_i && w_fifo_empty;
    assign w_pop      = w_resp_hit && bus.resp_yumi_i[w_head];

    assign bus.resp_v_o            = w_resp_hit ? (num_req_p'(1) << w_head) : '0;
    assign bus.resp_crypt_o        = w_out_en ? bus.enc_crypt_i : '0;
    assign bus.enc_yumi_o          = w_pop || w_spurious;
    assign bus.enc_invalid_cache_o = w_flush_pulse;
    assign bus.flush_done_o        = w_flush_pulse;
    assign bus.outstanding_o       = w_out_en ? r_count : '0;
    assign bus.error_o             = w_out_en && r_error;

    always_ff @(posedge clk_i) begin
        if (w_issue) r_fifo_mem[r_wr_ptr] <= w_grant;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_post_rst <= 1'b1;
            r_error    <= 1'b0;
            r_rr_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_post_rst <= 1'b0;
            if (w_spurious) r_error <= 1'b1;
            if (w_issue) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
                r_rr_ptr <= w_rr_nxt;
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + cnt_width_lp'(1);
                2'b01:   r_count <= r_count - cnt_width_lp'(1);
                default: ;
            endcase
        end
    end
endmodule
